ddr_wr_axi_master: RTL and testbench

Single-clock AXI4 write master between the frame line-buffer writer and the DDR controller AXI slave port. Accepts one line-write request (`ddr_wreq`/`ddr_waddr`/`ddr_wr_len`) and pulls beats with `ddr_wdata_req`. Splits the request into AXI4 INCR bursts that respect `MAX_BURST` and the 4 KB boundary. Pulses `ddr_wdone` once every burst of the request has received its write response.

---
 rtl/ddr_wr_axi_master.sv | 197 +++++++++++++++++++
 tb/tb_ddr_wr_axi_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_axi_master.sv
// ddr_wr_axi_master
// Single-clock AXI4 write master. Takes one line-write request, splits it into
// INCR bursts bounded by MAX_BURST and the 4 KB line, pulls beats from the
// line-buffer writer through a 4-entry FIFO and pulses ddr_wdone once every
// burst has been acknowledged on the B channel.
module ddr_wr_axi_master #(
  parameter int ADDR_WIDTH     = 27,
  parameter int DQ_WIDTH       = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST      = 16
) (
  input  logic                      ddr_clk,
  input  logic                      ddr_rst,
  // line-buffer side
  input  logic                      ddr_wreq,
  input  logic [ADDR_WIDTH-1:0]     ddr_waddr,
  input  logic [LEN_WIDTH-1:0]      ddr_wr_len,
  input  logic [8*DQ_WIDTH-1:0]     ddr_wdata,
  output logic                      ddr_wdata_req,
  output logic                      ddr_wdone,
  // AXI4 write address channel
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  // AXI4 write data channel
  output logic [8*DQ_WIDTH-1:0]     m_axi_wdata,
  output logic [DQ_WIDTH-1:0]       m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  // AXI4 write response channel
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic                      err_bresp
);

  localparam int DATA_W     = 8 * DQ_WIDTH;
  localparam int BEAT_SHIFT = $clog2(DQ_WIDTH);      // bytes per beat = DQ_WIDTH
  localparam int WORD_SHIFT = $clog2(DQ_WIDTH / 8);  // bytes per DQ word

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ADDR, S_DATA, S_RESP, S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  logic [AXI_ADDR_WIDTH-1:0] r_baddr;      // byte address of the next burst
  logic [LEN_WIDTH-1:0]      r_remain;     // beats still to be issued
  logic [8:0]                r_blen;       // beats in the current burst (1..256)
  logic [8:0]                r_pulled;     // beats pulled upstream in this burst
  logic [8:0]                r_sent;       // beats accepted on W in this burst
  logic                      r_err;

  logic [12:0]               w_to4k;
  logic [8:0]                w_blen;
  logic [LEN_WIDTH-1:0]      w_remain_next;

  // beat FIFO between the pull strobe and the W channel
  logic [DATA_W-1:0]         r_mem [4];
  logic [1:0]                r_wr_ptr;
  logic [1:0]                r_rd_ptr;
  logic [2:0]                r_count;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_wvalid;
  logic                      w_wfire;

  assign m_axi_awsize  = 3'(BEAT_SHIFT);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign m_axi_awaddr  = r_baddr;
  assign m_axi_awlen   = (r_state == S_ADDR) ? 8'(r_blen - 9'd1) : 8'd0;

  assign w_wvalid      = (r_count != 3'd0);
  assign w_wfire       = w_wvalid && m_axi_wready;
  assign m_axi_wvalid  = w_wvalid;
  assign m_axi_wdata   = r_mem[r_rd_ptr];
  assign m_axi_wlast   = w_wvalid && (r_sent == (r_blen - 9'd1));

  assign w_push        = ddr_wdata_req;
  assign w_pop         = w_wfire;
  assign w_remain_next = r_remain - LEN_WIDTH'(r_blen);
  assign err_bresp     = r_err;

  // Burst length: smallest of remaining beats, MAX_BURST and beats left before the 4 KB line.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    w_to4k = (13'h1000 - {1'b0, r_baddr[11:0]}) >> BEAT_SHIFT;
    w_blen = 9'(MAX_BURST);
    if (32'(r_remain) < 32'(w_blen)) w_blen = 9'(r_remain);
    if (32'(w_to4k) < 32'(w_blen))   w_blen = 9'(w_to4k);
    // an unaligned start inside the last beat of a 4 KB line still moves one beat
    if (w_blen == 9'd0)              w_blen = 9'd1;
  end

  // State register.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (ddr_rst) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode and per-state handshake outputs.
  always_comb begin
    w_next_state  = r_state;
    m_axi_awvalid = 1'b0;
    m_axi_bready  = 1'b0;
    ddr_wdone     = 1'b0;
    ddr_wdata_req = 1'b0;
    case (r_state)
      S_IDLE: if (ddr_wreq) w_next_state = S_CALC;
      S_CALC: w_next_state = S_ADDR;
      S_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_next_state = S_DATA;
      end
      S_DATA: begin
        // ignore a same-cycle pop so the FIFO can never overflow
        ddr_wdata_req = (r_pulled < r_blen) && (r_count <= 3'd3);
        if (w_wfire && m_axi_wlast) w_next_state = S_RESP;
      end
      S_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) w_next_state = (w_remain_next == '0) ? S_DONE : S_CALC;
      end
      S_DONE: begin
        ddr_wdone    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request bookkeeping: address, remaining beats, burst length and beat counters.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      r_baddr  <= '0;
      r_remain <= '0;
      r_blen   <= 9'd0;
      r_pulled <= 9'd0;
      r_sent   <= 9'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (ddr_wreq) begin
          r_baddr  <= AXI_ADDR_WIDTH'(ddr_waddr) << WORD_SHIFT;
          r_remain <= ddr_wr_len;
        end
        S_CALC: begin
          r_blen   <= w_blen;
          r_pulled <= 9'd0;
          r_sent   <= 9'd0;
        end
        S_DATA: begin
          if (ddr_wdata_req) r_pulled <= r_pulled + 9'd1;
          if (w_wfire)       r_sent   <= r_sent + 9'd1;
        end
        S_RESP: if (m_axi_bvalid) begin
          r_baddr  <= r_baddr + (AXI_ADDR_WIDTH'(r_blen) << BEAT_SHIFT);
          r_remain <= w_remain_next;
          if (m_axi_bresp != 2'b00) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: the pulled word is captured in the same cycle as its strobe.
  always_ff @(posedge ddr_clk) begin
    // NOTE: storage is not reset; emptiness is tracked by the pointers and count alone.
    if (w_push) r_mem[r_wr_ptr] <= ddr_wdata;
  end

endmodule

// File: tb/tb_ddr_wr_axi_master.sv
// tb_ddr_wr_axi_master
// Table-driven bench with a reactive AXI slave, an upstream beat source and
// scoreboard queues for expected AW bursts and W data.
module tb_ddr_wr_axi_master;

  logic         ddr_clk = 1'b0;
  logic         ddr_rst = 1'b1;
  logic         ddr_wreq = 1'b0;
  logic [26:0]  ddr_waddr = '0;
  logic [15:0]  ddr_wr_len = '0;
  logic [255:0] ddr_wdata = '0;
  logic         ddr_wdata_req;
  logic         ddr_wdone;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid;
  logic         m_axi_awready = 1'b0;
  logic [255:0] m_axi_wdata;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_wvalid;
  logic         m_axi_wready = 1'b0;
  logic [1:0]   m_axi_bresp = 2'b00;
  logic         m_axi_bvalid = 1'b0;
  logic         m_axi_bready;
  logic         err_bresp;

  ddr_wr_axi_master dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
    .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len),
    .ddr_wdata(ddr_wdata), .ddr_wdata_req(ddr_wdata_req), .ddr_wdone(ddr_wdone),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .err_bresp(err_bresp)
  );

  always #5 ddr_clk = ~ddr_clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_exp_t;

  typedef struct {
    logic [26:0] waddr;
    int          len;
    int          aw_delay;
    int          b_delay;
    int          wr_mode;    // 0: wready always 1, 1: pattern 1,0,0,1
    int          err_burst;  // 1-based burst answered with SLVERR, 0 = none
    int          exp_nb;     // bursts expected on AW
    logic        exp_err;
  } vec_t;

  localparam int NVEC  = 7;
  localparam int LIMIT = 3000;

  vec_t         vecs [NVEC];
  aw_exp_t      exp_aw [$];
  logic [255:0] exp_data [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_beat();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference burst split: 32-byte beats, MAX_BURST 16, no burst crosses 4 KB.
  task automatic build_model(input logic [26:0] waddr, input int len);
    logic [31:0] addr;
    int rem, to4k, b;
    addr = 32'(waddr) << 2;
    rem  = len;
    while (rem > 0) begin
      to4k = (4096 - int'(addr[11:0])) / 32;
      b = rem;
      if (b > 16)   b = 16;
      if (b > to4k) b = to4k;
      if (b < 1)    b = 1;
      exp_aw.push_back('{addr: addr, len: 8'(b - 1)});
      addr = addr + 32'(b * 32);
      rem  = rem - b;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"},  m_axi_awvalid, 1'b0);
    check({tag, "_wvalid"},   m_axi_wvalid,  1'b0);
    check({tag, "_wlast"},    m_axi_wlast,   1'b0);
    check({tag, "_bready"},   m_axi_bready,  1'b0);
    check({tag, "_wdata_req"}, ddr_wdata_req, 1'b0);
    check({tag, "_wdone"},    ddr_wdone,     1'b0);
    check({tag, "_err"},      err_bresp,     1'b0);
    check({tag, "_awaddr"},   m_axi_awaddr,  32'h0);
    check({tag, "_awlen"},    m_axi_awlen,   8'h0);
  endtask

  task automatic idle_inputs();
    ddr_wreq = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge ddr_clk);
    ddr_rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge ddr_clk);
    ddr_rst = 1'b0;
  endtask

  task automatic run_case(input string nm, input vec_t v, input int abort_after);
    aw_exp_t      e;
    logic [255:0] cur_data, prev_wdata, ed;
    logic [31:0]  prev_awaddr;
    logic [7:0]   prev_awlen, cur_len;
    logic         prev_wlast, aw_stall, w_stall, in_resp, aw_done, done;
    int pulls, beats, nb_aw, nb_b, occ, occ_max, aw_cnt, b_wait, beat_in_burst;
    int first_aw_k, last_b_k, wdone_k, wdone_cnt, viol_stab, viol_early, viol_bready;

    apply_reset();
    exp_aw.delete();
    exp_data.delete();
    build_model(v.waddr, v.len);
    cur_data = rnd_beat();
    {pulls, beats, nb_aw, nb_b, occ, occ_max, aw_cnt, b_wait, beat_in_burst} = '0;
    {viol_stab, viol_early, viol_bready, wdone_cnt} = '0;
    first_aw_k = -1; last_b_k = -100; wdone_k = -1;
    {aw_stall, w_stall, in_resp, aw_done, done} = '0;
    prev_awaddr = '0; prev_awlen = '0; prev_wdata = '0; prev_wlast = 1'b0; cur_len = '0;
    ddr_waddr  = v.waddr;
    ddr_wr_len = 16'(v.len);

    for (int k = 0; k < LIMIT; k++) begin
      @(negedge ddr_clk);
      if (abort_after > 0 && beats >= abort_after) begin
        ddr_rst = 1'b1;
        #1;
        check_reset_outputs({nm, "_abort"});
        check({nm, "_abort_no_done"}, 32'(wdone_cnt), 32'd0);
        @(negedge ddr_clk);
        idle_inputs();
        check({nm, "_abort_held_no_done"}, ddr_wdone, 1'b0);
        @(negedge ddr_clk);
        ddr_rst = 1'b0;
        return;
      end
      // drive slave and upstream for this cycle
      ddr_wreq      = (pulls == 0);
      ddr_wdata     = cur_data;
      m_axi_awready = (aw_cnt >= v.aw_delay);
      m_axi_wready  = (v.wr_mode == 0) ? 1'b1 : ((k % 4) == 0 || (k % 4) == 3);
      if (in_resp) begin
        if (b_wait > 0) begin m_axi_bvalid = 1'b0; b_wait--; end
        else             m_axi_bvalid = 1'b1;
      end else m_axi_bvalid = 1'b0;
      m_axi_bresp = (nb_b + 1 == v.err_burst) ? 2'b10 : 2'b00;
      #1;
      // observe
      if (m_axi_bready !== in_resp) viol_bready++;
      if (m_axi_awvalid && first_aw_k < 0) first_aw_k = k;
      if (aw_stall && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen))
        viol_stab++;
      if (w_stall && (!m_axi_wvalid || m_axi_wdata !== prev_wdata || m_axi_wlast !== prev_wlast))
        viol_stab++;
      aw_stall = m_axi_awvalid && !m_axi_awready;
      w_stall  = m_axi_wvalid && !m_axi_wready;
      prev_awaddr = m_axi_awaddr; prev_awlen = m_axi_awlen;
      prev_wdata  = m_axi_wdata;  prev_wlast = m_axi_wlast;

      if (ddr_wdata_req) begin
        if (!aw_done) viol_early++;
        exp_data.push_back(cur_data);
        cur_data = rnd_beat();
        pulls++;
        occ++;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw.size() == 0) check({nm, "_aw_unexpected"}, 32'(nb_aw), 32'(v.exp_nb));
        else begin
          e = exp_aw.pop_front();
          check({nm, "_awaddr"}, m_axi_awaddr, e.addr);
          check({nm, "_awlen"},  m_axi_awlen,  e.len);
          cur_len = e.len;
        end
        check({nm, "_awsize"},  m_axi_awsize,  3'd5);
        check({nm, "_awburst"}, m_axi_awburst, 2'b01);
        check({nm, "_wstrb"},   m_axi_wstrb,   32'hFFFF_FFFF);
        aw_done = 1'b1;
        aw_cnt  = 0;
        nb_aw++;
      end else if (m_axi_awvalid) aw_cnt++;
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_data.size() == 0) check({nm, "_w_unexpected"}, 32'(beats), 32'(pulls));
        else begin
          ed = exp_data.pop_front();
          check({nm, "_wdata"}, m_axi_wdata, ed);
        end
        check({nm, "_wlast"}, m_axi_wlast, (beat_in_burst == int'(cur_len)));
        beat_in_burst++;
        beats++;
        occ--;
        if (m_axi_wlast) begin
          in_resp = 1'b1; b_wait = v.b_delay; beat_in_burst = 0;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        nb_b++; in_resp = 1'b0; aw_done = 1'b0; last_b_k = k;
      end
      if (ddr_wdone) begin
        wdone_cnt++;
        if (wdone_k < 0) wdone_k = k;
      end
      if (occ > occ_max) occ_max = occ;
      if (wdone_k >= 0 && k >= wdone_k + 3) begin
        done = 1'b1;
        break;
      end
    end

    check({nm, "_completed"},      done, 1'b1);
    check({nm, "_aw_latency"},     32'(first_aw_k), 32'd2);
    check({nm, "_bursts"},         32'(nb_aw), 32'(v.exp_nb));
    check({nm, "_responses"},      32'(nb_b), 32'(v.exp_nb));
    check({nm, "_pulls"},          32'(pulls), 32'(v.len));
    check({nm, "_beats"},          32'(beats), 32'(v.len));
    check({nm, "_aw_left"},        32'(exp_aw.size()), 32'd0);
    check({nm, "_fifo_max_le4"},   (occ_max <= 4), 1'b1);
    check({nm, "_stable_stall"},   32'(viol_stab), 32'd0);
    check({nm, "_pull_after_aw"},  32'(viol_early), 32'd0);
    check({nm, "_bready_in_resp"}, 32'(viol_bready), 32'd0);
    check({nm, "_wdone_pulses"},   32'(wdone_cnt), 32'd1);
    check({nm, "_wdone_after_b"},  32'(wdone_k - last_b_k), 32'd1);
    check({nm, "_err_bresp"},      err_bresp, v.exp_err);
  endtask

  initial begin
    vecs[0] = '{waddr: 27'h000, len: 40, aw_delay: 0,  b_delay: 0,  wr_mode: 0, err_burst: 0, exp_nb: 3, exp_err: 1'b0};
    vecs[1] = '{waddr: 27'h3F8, len: 4,  aw_delay: 0,  b_delay: 0,  wr_mode: 0, err_burst: 0, exp_nb: 2, exp_err: 1'b0};
    vecs[2] = '{waddr: 27'h000, len: 16, aw_delay: 0,  b_delay: 0,  wr_mode: 1, err_burst: 0, exp_nb: 1, exp_err: 1'b0};
    vecs[3] = '{waddr: 27'h100, len: 20, aw_delay: 10, b_delay: 20, wr_mode: 0, err_burst: 0, exp_nb: 2, exp_err: 1'b0};
    vecs[4] = '{waddr: 27'h000, len: 40, aw_delay: 0,  b_delay: 3,  wr_mode: 0, err_burst: 2, exp_nb: 3, exp_err: 1'b1};
    vecs[5] = '{waddr: 27'h3C0, len: 10, aw_delay: 2,  b_delay: 1,  wr_mode: 1, err_burst: 0, exp_nb: 2, exp_err: 1'b0};
    vecs[6] = '{waddr: 27'h008, len: 1,  aw_delay: 0,  b_delay: 0,  wr_mode: 0, err_burst: 0, exp_nb: 1, exp_err: 1'b0};

    // reset state while reset is held
    #12;
    check_reset_outputs("reset");
    ddr_rst = 1'b0;

    // literal spot checks of the burst split against the documented scenarios
    build_model(27'h000, 40);
    check("model_b0_addr", exp_aw[0].addr, 32'h0);
    check("model_b1_addr", exp_aw[1].addr, 32'h200);
    check("model_b2_addr", exp_aw[2].addr, 32'h400);
    check("model_b2_len",  exp_aw[2].len,  8'd7);
    exp_aw.delete();
    build_model(27'h3F8, 4);
    check("model_4k_b0_addr", exp_aw[0].addr, 32'hFE0);
    check("model_4k_b1_addr", exp_aw[1].addr, 32'h1000);
    check("model_4k_b1_len",  exp_aw[1].len,  8'd2);

    for (int i = 0; i < NVEC; i++) run_case($sformatf("vec%0d", i), vecs[i], 0);

    // reset in the middle of DATA, then the single-line scenario again
    run_case("abort", vecs[0], 5);
    run_case("after_abort", vecs[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
